// File: rtl/uart_pkg.sv
// Shared definitions for the USART controllers: the TX frame state
// encoding, parity mode encodings and the smallest usable bit period.
package uart_pkg;

  // The S_ prefix keeps the parity state literal clear of the PARITY
  // parameter that every controller carries.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [15:0] PRESCALER_MIN = 16'd2;

  // A bit period below two cycles cannot be sequenced, so those values are
  // raised to the minimum rather than rejected.
  function automatic logic [15:0] clamp_prescaler(input logic [15:0] p);
    return (p < PRESCALER_MIN) ? PRESCALER_MIN : p;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between a requester and the UART transmit scheduler.
//   tx_data  : byte to send, LSB first
//   tx_valid : tx_data is valid; held by the requester until tx_ready
//   tx_ready : scheduler can accept a frame
interface uart_tx_sched_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/baud_tick_gen.sv
// Restartable bit-period counter. The period is captured on load and held
// until the next load, so a frame runs at one fixed rate.
//   clk, reset : system clock, synchronous active-low reset
//   load       : restart the count and capture prescaler (clamped)
//   run        : count while high
//   prescaler  : requested bit period in clk cycles
//   bit_end    : high on the last cycle (count P-1) of each bit period
module baud_tick_gen
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] prescaler,
  output logic        bit_end
);

  logic [15:0] period_q;
  logic [15:0] count_q;

  assign bit_end = run && (count_q == period_q - 16'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      period_q <= PRESCALER_MIN;
    end else if (load) begin
      count_q  <= '0;
      period_q <= clamp_prescaler(prescaler);
    end else if (run) begin
      count_q  <= bit_end ? '0 : count_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: accepts a byte over the handshake and sends
// start, data (LSB first), optional parity and stop bits on tx.
//   clk, reset : system clock, synchronous active-low reset
//   prescaler  : bit period in clk cycles, captured at frame accept
//   bus        : tx_data / tx_valid in, tx_ready out
//   tx         : registered serial line, idle high
//   busy       : frame in progress
//   done       : one-cycle pulse in the first idle cycle after a frame
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          prescaler,
  uart_tx_sched_if.slave       bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  state_e                 state_q, state_n;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
  logic [DATA_BITS-1:0]   shreg_q, shreg_n;
  logic                   par_q, par_n;
  logic                   ready_q, ready_n;
  logic                   tx_n, busy_n, done_n;
  logic                   accept;
  logic                   bit_end;

  assign accept       = bus.tx_valid && ready_q;
  assign bus.tx_ready = ready_q;

  baud_tick_gen u_baud (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .run       (busy),
    .prescaler (prescaler),
    .bit_end   (bit_end)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shreg_n   = shreg_q;
    par_n     = par_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_START;
          bit_cnt_n = '0;
          shreg_n   = bus.tx_data;
          par_n     = (^bus.tx_data) ^ (PARITY == PAR_ODD);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_n = shreg_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            state_n   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
    busy_n  = (state_n != S_IDLE);
    ready_n = (state_n == S_IDLE);
    done_n  = (state_q == S_STOP) && (state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      ready_q   <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      par_q     <= par_n;
      tx        <= tx_n;
      busy      <= busy_n;
      ready_q   <= ready_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: three instances (8N1, 8E2, 8O1) driven one at a
// time; every cycle of each frame is compared with a waveform built from
// the frame rules (bit list times clamped period).
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] prescaler;
  logic [2:0]  valid_d;
  logic [2:0]  tx_w, busy_w, done_w, ready_w;
  logic [7:0]  data_d [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_sched_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_sched_if #(.DATA_BITS(8)) bus2 ();

  assign bus0.tx_valid = valid_d[0];
  assign bus1.tx_valid = valid_d[1];
  assign bus2.tx_valid = valid_d[2];
  assign bus0.tx_data  = data_d[0];
  assign bus1.tx_data  = data_d[1];
  assign bus2.tx_data  = data_d[2];
  assign ready_w[0]    = bus0.tx_ready;
  assign ready_w[1]    = bus1.tx_ready;
  assign ready_w[2]    = bus2.tx_ready;

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .prescaler(prescaler), .bus(bus0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .prescaler(prescaler), .bus(bus1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut2 (
    .clk(clk), .reset(reset), .prescaler(prescaler), .bus(bus2),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  // Configuration of each instance, mirrored for the reference model.
  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int par_of(input int i);
    return i;  // 0 none, 1 even, 2 odd
  endfunction

  function automatic int eff_period(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int frame_len(input int i, input int p);
    return (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * eff_period(p);
  endfunction

  // Line level of bit slot b in a frame: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_of(i) != 0 && b == 9) return (^d) ^ (par_of(i) == 2);
    return 1'b1;
  endfunction

  // {tx, busy, tx_ready, done}
  function automatic logic [3:0] status(input int i);
    return {tx_w[i], busy_w[i], ready_w[i], done_w[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte at a negedge and return just after the accept edge.
  task automatic start_frame(input int i, input logic [7:0] d, input int p, input bit keep);
    @(negedge clk);
    prescaler  = 16'(p);
    data_d[i]  = d;
    valid_d[i] = 1'b1;
    check($sformatf("ready_before_accept dut%0d", i), 32'(ready_w[i]), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) valid_d[i] = 1'b0;
    data_d[i] = 8'($urandom);  // must not disturb the frame in flight
  endtask

  // Compare every cycle from the accept edge to the done cycle. Optionally
  // retune the prescaler mid-frame, or assert reset at cycle abort_at.
  task automatic check_frame(input int i, input logic [7:0] d, input int p,
                             input int p_mid, input int abort_at);
    int pe;
    int len;
    pe  = eff_period(p);
    len = frame_len(i, p);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check($sformatf("dut%0d d=%02h p=%0d cyc%0d", i, d, p, k),
            32'(status(i)), 32'({exp_bit(i, d, k / pe), 3'b100}));
      if (k == 1 && p_mid >= 0) prescaler = 16'(p_mid);
      if (k == abort_at) begin
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check($sformatf("dut%0d d=%02h p=%0d done_cycle", i, d, p),
          32'(status(i)), 32'(4'b1011));
  endtask

  initial begin
    logic [7:0] d;
    int         p;

    reset     = 1'b0;
    prescaler = 16'd4;
    valid_d   = '0;
    for (int i = 0; i < 3; i++) data_d[i] = 8'h00;

    // Reset held with a pending request: stays idle.
    valid_d[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        check($sformatf("reset_idle dut%0d", i), 32'(status(i)), 32'(4'b1010));
    end
    valid_d[0] = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(status(0)), 32'(4'b1010));

    // Basic 8N1 frame.
    start_frame(0, 8'hA5, 4, 1'b0);
    check_frame(0, 8'hA5, 4, -1, -1);
    @(negedge clk);
    check("done_single_pulse", 32'(status(0)), 32'(4'b1010));

    // Even parity, two stops; odd parity.
    start_frame(1, 8'h07, 3, 1'b0);
    check_frame(1, 8'h07, 3, -1, -1);
    start_frame(2, 8'h07, 3, 1'b0);
    check_frame(2, 8'h07, 3, -1, -1);

    // Clamp of 0 and 1, then retune 4 -> 8 mid-frame.
    d = 8'($urandom);
    start_frame(0, d, 0, 1'b0);
    check_frame(0, d, 0, -1, -1);
    d = 8'($urandom);
    start_frame(0, d, 1, 1'b0);
    check_frame(0, d, 1, -1, -1);
    d = 8'($urandom);
    start_frame(0, d, 4, 1'b0);
    check_frame(0, d, 4, 8, -1);
    @(negedge clk);
    valid_d[0] = 1'b1;
    data_d[0]  = 8'h3C;
    @(posedge clk);
    #1;
    valid_d[0] = 1'b0;
    check_frame(0, 8'h3C, 8, -1, -1);

    // Back-to-back frames with tx_valid held high.
    start_frame(0, 8'h55, 4, 1'b1);
    data_d[0] = 8'hAA;
    check_frame(0, 8'h55, 4, -1, -1);
    @(posedge clk);
    #1;
    valid_d[0] = 1'b0;
    check_frame(0, 8'hAA, 4, -1, -1);

    // Reset during data bit 3, then a normal frame.
    d = 8'($urandom);
    start_frame(0, d, 4, 1'b0);
    check_frame(0, d, 4, -1, 17);
    @(negedge clk);
    check("midframe_reset_line_high", 32'(status(0)), 32'(4'b1010));
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_reset_no_done", 32'(status(0)), 32'(4'b1010));
    end
    d = 8'($urandom);
    start_frame(0, d, 3, 1'b0);
    check_frame(0, d, 3, -1, -1);

    // Random frames on every instance.
    for (int i = 0; i < 3; i++) begin
      repeat (5) begin
        d = 8'($urandom);
        p = int'($urandom_range(0, 6));
        start_frame(i, d, p, 1'b0);
        check_frame(i, d, p, -1, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
